arbiter_n_to_1_request: RTL and testbench

- Merges memory request packets from NUM_MEMORY_REQUESTOR upstream requestors into one registered request stream.
- Sits directly upstream of the 1-to-N request demux stage and feeds its request input.
- Uses round-robin arbitration and valid/ready handshakes on both sides.
- Packets carrying an all-zero route mask are consumed and dropped, so they never reach the downstream FIFO.

---
 rtl/arbiter_n_to_1_request.sv | 103 ++++++++++
 tb/tb_arbiter_n_to_1_request.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_n_to_1_request.sv
// Round-robin merge of N memory request streams into one registered stream.
// Zero-route packets are consumed and counted instead of forwarded.
module arbiter_n_to_1_request #(
    parameter int NUM_MEMORY_REQUESTOR = 2,
    parameter int DATA_WIDTH           = 128,
    parameter int ROUTE_WIDTH          = 8
) (
    input  logic                                         ap_clk,
    input  logic                                         ap_rst_n,
    input  logic [NUM_MEMORY_REQUESTOR-1:0]              request_in_valid,
    input  logic [NUM_MEMORY_REQUESTOR*DATA_WIDTH-1:0]   request_in_payload,
    output logic [NUM_MEMORY_REQUESTOR-1:0]              request_in_ready,
    output logic                                         request_out_valid,
    output logic [DATA_WIDTH-1:0]                        request_out_payload,
    input  logic                                         request_out_ready,
    output logic [15:0]                                  drop_count,
    output logic                                         fifo_setup_signal
);

    localparam int N  = NUM_MEMORY_REQUESTOR;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic                  rst;
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         ptr_nxt;
    logic [PW-1:0]         gnt;
    logic                  found;
    logic [DATA_WIDTH-1:0] gnt_payload;
    logic                  route_zero;
    logic                  load_en;
    logic                  accept;
    logic                  load;

    // Two passes: indices at/after the pointer first, then wrap to the lowest.
    always_comb begin
        found       = 1'b0;
        gnt         = '0;
        gnt_payload = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && request_in_valid[i] && i >= int'(ptr)) begin
                found = 1'b1;
                gnt   = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && request_in_valid[i]) begin
                found = 1'b1;
                gnt   = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (gnt == PW'(i)) begin
                gnt_payload = request_in_payload[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign route_zero = ~|gnt_payload[ROUTE_WIDTH-1:0];
    assign load_en    = ~request_out_valid | request_out_ready;
    assign accept     = found & ~rst & (load_en | route_zero);
    assign load       = accept & ~route_zero;
    assign ptr_nxt    = (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;

    always_comb begin
        request_in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (accept && gnt == PW'(i)) begin
                request_in_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rst               <= 1'b1;
            fifo_setup_signal <= 1'b1;
            request_out_valid <= 1'b0;
            ptr               <= '0;
            drop_count        <= '0;
        end else begin
            rst               <= 1'b0;
            fifo_setup_signal <= rst;
            if (accept) begin
                ptr <= ptr_nxt;
            end
            if (load) begin
                request_out_valid <= 1'b1;
            end else if (load_en) begin
                request_out_valid <= 1'b0;
            end
            if (accept && route_zero && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (load) begin
            request_out_payload <= gnt_payload;
        end
    end

endmodule

// File: tb/tb_arbiter_n_to_1_request.sv
// Scoreboard bench for arbiter_n_to_1_request with two requestors.
// A reference model predicts grants; accepted payloads queue for output checks.
module tb_arbiter_n_to_1_request;

    localparam int N  = 2;
    localparam int DW = 128;
    localparam int RW = 8;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n;
    logic [N-1:0]    vin;
    logic [N*DW-1:0] pin;
    logic [N-1:0]    rdy;
    logic            ov;
    logic [DW-1:0]   op;
    logic            oready;
    logic [15:0]     dc;
    logic            setup;

    arbiter_n_to_1_request #(
        .NUM_MEMORY_REQUESTOR(N),
        .DATA_WIDTH(DW),
        .ROUTE_WIDTH(RW)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .request_in_valid(vin),
        .request_in_payload(pin),
        .request_in_ready(rdy),
        .request_out_valid(ov),
        .request_out_payload(op),
        .request_out_ready(oready),
        .drop_count(dc),
        .fifo_setup_signal(setup)
    );

    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] src0[$];
    logic [DW-1:0] src1[$];
    logic [DW-1:0] exp_q[$];
    bit            flood;

    bit m_rst, m_setup, m_outv;
    int m_ptr, m_drop;

    task automatic check_eq(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat(input logic [7:0] tag,
                                           input logic [7:0] route);
        return {8'hA5, 104'h0, tag, route};
    endfunction

    task automatic run_cycle();
        logic [N-1:0]    v;
        logic [N*DW-1:0] p;
        logic [N-1:0]    er;
        logic [DW-1:0]   gp;
        bit found, zr, le, acc;
        int g;
        v = '0;
        p = '0;
        if (flood) begin
            v[0] = 1'b1;
        end else if (src0.size() > 0) begin
            v[0] = 1'b1;
            p[DW-1:0] = src0[0];
        end
        if (src1.size() > 0) begin
            v[1] = 1'b1;
            p[2*DW-1:DW] = src1[0];
        end
        vin = v;
        pin = p;
        #1;
        le = !m_outv || oready;
        found = 0;
        g = 0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (!found && v[idx]) begin
                found = 1;
                g = idx;
            end
        end
        gp  = (g == 0) ? p[DW-1:0] : p[2*DW-1:DW];
        zr  = (gp[RW-1:0] == '0);
        acc = found && !m_rst && (le || zr);
        er  = acc ? N'(1 << g) : '0;
        check_eq("in_ready", DW'(rdy), DW'(er));
        check_eq("out_valid", DW'(ov), DW'(m_outv));
        check_eq("drop_count", DW'(dc), DW'(m_drop));
        check_eq("setup", DW'(setup), DW'(m_setup));
        if (m_outv) begin
            if (exp_q.size() > 0) begin
                check_eq("payload", op, exp_q[0]);
            end else begin
                n_cmp++;
                n_err++;
                $display("FAIL payload: got %0h expected none (scoreboard empty)", op);
            end
        end
        @(posedge ap_clk);
        if (acc) begin
            if (g == 0 && !flood) void'(src0.pop_front());
            else if (g == 1) void'(src1.pop_front());
        end
        if (!ap_rst_n) begin
            m_rst = 1; m_setup = 1; m_outv = 0;
            m_ptr = 0; m_drop = 0;
            exp_q.delete();
        end else begin
            m_setup = m_rst;
            m_rst = 0;
            if (m_outv && oready) void'(exp_q.pop_front());
            if (acc) begin
                m_ptr = (g + 1) % N;
                if (!zr) begin
                    exp_q.push_back(gp);
                end else if (m_drop != 16'hFFFF) begin
                    m_drop++;
                end
            end
            if (acc && !zr) m_outv = 1;
            else if (le) m_outv = 0;
        end
        @(negedge ap_clk);
    endtask

    task automatic run(input int n);
        repeat (n) run_cycle();
    endtask

    initial begin
        ap_rst_n = 1'b0;
        vin = '0;
        pin = '0;
        oready = 1'b1;
        flood = 0;
        @(posedge ap_clk);
        @(negedge ap_clk);
        m_rst = 1; m_setup = 1; m_outv = 0; m_ptr = 0; m_drop = 0;
        run(3);
        ap_rst_n = 1'b1;
        run(3);

        src1.push_back(beat(8'h11, 8'h01));
        src1.push_back(beat(8'h12, 8'h01));
        src1.push_back(beat(8'h13, 8'h01));
        run(6);

        for (int k = 0; k < 4; k++) begin
            src0.push_back(beat(8'h20 + 8'(k), 8'h03));
            src1.push_back(beat(8'h30 + 8'(k), 8'h80));
        end
        run(10);

        src0.push_back(beat(8'h40, 8'h01));
        run(2);
        oready = 1'b0;
        src0.push_back(beat(8'h41, 8'h01));
        src1.push_back(beat(8'h50, 8'h04));
        run(5);
        oready = 1'b1;
        run(5);

        oready = 1'b0;
        src1.push_back(beat(8'h60, 8'h02));
        run(2);
        src0.push_back(beat(8'h61, 8'h00));
        run(3);
        check_eq("drop_one", DW'(dc), DW'(16'd1));
        oready = 1'b1;
        run(2);
        flood = 1;
        run(70000);
        check_eq("drop_sat", DW'(dc), DW'(16'hFFFF));
        flood = 0;
        run(2);

        oready = 1'b0;
        src0.push_back(beat(8'h70, 8'h01));
        src1.push_back(beat(8'h71, 8'h01));
        run(2);
        ap_rst_n = 1'b0;
        run(2);
        src0.push_back(beat(8'h72, 8'h01));
        src1.push_back(beat(8'h73, 8'h01));
        ap_rst_n = 1'b1;
        oready = 1'b1;
        run(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
